fft_cmd_seq: RTL and testbench

- Sequencer for the custom FFT/IFFT instruction class. It replaces fixed per-point funct7 decode with a parametrised N-point command decoder plus a stage sequencer.
- Accepts decoded R-type FFT commands from the execute stage and drives the butterfly datapath: load strobes, per-stage controls, export selects.
- Stalls the pipeline while a transform runs.
- Tracks loaded points, result validity and protocol errors.

---
 rtl/fft_cmd_seq_pkg.sv | 25 ++
 rtl/fft_stage_timer.sv | 51 +++++
 rtl/fft_cmd_seq.sv | 163 ++++++++++++++++
 tb/tb_fft_cmd_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cmd_seq_pkg.sv
// Shared constants for the FFT command sequencer: ALU class code, opcodes, states.
// Opcode FFT_OP_PERF is only decoded when FFT_PERF_EN is defined.
package fft_cmd_seq_pkg;

  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [2:0] FFT_OP_LOAD     = 3'b001;
  localparam logic [2:0] FFT_OP_CAL_FFT  = 3'b010;
  localparam logic [2:0] FFT_OP_CAL_IFFT = 3'b011;
  localparam logic [2:0] FFT_OP_EXP_RE   = 3'b100;
  localparam logic [2:0] FFT_OP_EXP_IM   = 3'b101;
  localparam logic [2:0] FFT_OP_PERF     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fft_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] rsvd;
  } fft_funct7_t;

endpackage

// File: rtl/fft_stage_timer.sv
// Butterfly stage timer: cycle counter within a stage plus stage counter.
// Counters sit at zero whenever run is low.
module fft_stage_timer #(
  parameter int unsigned N_STAGES     = 3,
  parameter int unsigned STAGE_CYCLES = 2,
  parameter int unsigned STG_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             stage_go,
  output logic [STG_W-1:0] stage_idx,
  output logic             last_stage
);

  localparam int unsigned CYC_W = 4;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic             last_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      stg_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stg_q <= stg_d;
    end
  end

  always_comb begin
    cyc_d      = cyc_q;
    stg_d      = stg_q;
    last_cyc   = (cyc_q == CYC_W'(STAGE_CYCLES - 1));
    last_stage = run && last_cyc && (stg_q == STG_W'(N_STAGES - 1));
    if (!run || last_stage) begin
      cyc_d = '0;
      stg_d = '0;
    end else if (last_cyc) begin
      cyc_d = '0;
      stg_d = stg_q + STG_W'(1);
    end else begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  assign stage_go  = run && (cyc_q == '0);
  assign stage_idx = stg_q;

endmodule

// File: rtl/fft_cmd_seq.sv
// FFT/IFFT command decoder and stage sequencer driving the butterfly datapath.
// Define FFT_PERF_EN to add the perf_cycles counter and the PERF_RD opcode.
module fft_cmd_seq
  import fft_cmd_seq_pkg::*;
#(
  parameter int unsigned N_POINTS     = 8,
  parameter int unsigned IDX_W        = 6,
  parameter int unsigned STAGE_CYCLES = 2,
  parameter int unsigned DATA_W       = 32,
  localparam int unsigned STG_W       = $clog2($clog2(N_POINTS)) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        aluop,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [DATA_W-1:0] op_b,
  output logic              ld_we,
  output logic [IDX_W-1:0]  ld_idx,
  output logic              stage_go,
  output logic [STG_W-1:0]  stage_idx,
  output logic              inverse,
  output logic [IDX_W:0]    exp_sel,
  output logic              done,
  output logic              busy,
  output logic              err
`ifdef FFT_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int unsigned LOG2N = $clog2(N_POINTS);

  fft_state_e          state_q, state_d;
  logic [N_POINTS-1:0] mask_q, mask_d;
  logic                rv_q, rv_d;
  logic                err_q, err_d;
  logic                inv_q, inv_d;

  fft_funct7_t      f7;
  logic [IDX_W-1:0] idx;
  logic             in_range, is_ours, idle, all_loaded, last_stage;
  logic             unused_op_b;

  assign f7          = funct7;
  assign idx         = op_b[IDX_W-1:0];
  assign unused_op_b = ^op_b[DATA_W-1:IDX_W];
  assign in_range    = (32'(idx) < N_POINTS);
  assign is_ours     = cmd_valid && (aluop == ALU_RTYPE) && (funct3 == 3'h0) && (f7.rsvd == 4'h0);
  assign idle        = (state_q == ST_IDLE);
  assign all_loaded  = &mask_q;

  fft_stage_timer #(
    .N_STAGES    (LOG2N),
    .STAGE_CYCLES(STAGE_CYCLES),
    .STG_W       (STG_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q == ST_CALC),
    .stage_go  (stage_go),
    .stage_idx (stage_idx),
    .last_stage(last_stage)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (is_ours && all_loaded &&
                   (f7.op == FFT_OP_CAL_FFT || f7.op == FFT_OP_CAL_IFFT)) state_d = ST_CALC;
      ST_CALC: if (last_stage) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command decode plus next values of the sequencer bookkeeping flops.
  always_comb begin
    cmd_ready = idle;
    busy      = (state_q == ST_CALC);
    done      = (state_q == ST_DONE);
    inverse   = busy && inv_q;
    ld_we     = 1'b0;
    ld_idx    = '0;
    exp_sel   = '0;
    mask_d    = mask_q;
    rv_d      = rv_q;
    err_d     = err_q;
    inv_d     = inv_q;
    if (is_ours && idle) begin
      case (f7.op)
        FFT_OP_LOAD: begin
          if (in_range) begin
            ld_we  = 1'b1;
            ld_idx = idx;
            mask_d = mask_q | (N_POINTS'(1) << idx);
            rv_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        FFT_OP_CAL_FFT, FFT_OP_CAL_IFFT: begin
          if (all_loaded) inv_d = f7.op[0];
          else            err_d = 1'b1;
        end
        FFT_OP_EXP_RE, FFT_OP_EXP_IM: begin
          if (rv_q && in_range) exp_sel = {f7.op[0], idx};
          else                  err_d   = 1'b1;
        end
`ifdef FFT_PERF_EN
        FFT_OP_PERF: exp_sel = '1;
`endif
        default: ;
      endcase
    end
    // Each transform consumes the loaded points; a new CAL needs a full reload.
    if (busy && last_stage) begin
      mask_d = '0;
      rv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      rv_q   <= 1'b0;
      err_q  <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      rv_q   <= rv_d;
      err_q  <= err_d;
      inv_q  <= inv_d;
    end
  end

  assign err = err_q;

`ifdef FFT_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (busy && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fft_cmd_seq.sv
// Scoreboard bench for fft_cmd_seq (N=8, STAGE_CYCLES=2); PERF test under FFT_PERF_EN.
module tb_fft_cmd_seq;
  import fft_cmd_seq_pkg::*;

  localparam int unsigned IDX_W    = 6;
  localparam int unsigned SC       = 2;
  localparam int unsigned DW       = 32;
  localparam int unsigned LOG2N    = 3;
  localparam int unsigned STG_W    = 3;
  localparam int unsigned CALC_CYC = LOG2N * SC;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       aluop;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [DW-1:0]    op_b;
  logic             ld_we, stage_go, inverse, done, busy, err;
  logic [IDX_W-1:0] ld_idx;
  logic [STG_W-1:0] stage_idx;
  logic [IDX_W:0]   exp_sel;
`ifdef FFT_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  typedef struct packed {
    logic             ready;
    logic             go;
    logic [STG_W-1:0] stg;
    logic             inv;
    logic             dn;
    logic             bsy;
  } obs_t;

  obs_t exp_q[$];
  int   pass_cnt = 0;
  int   total    = 0;

  fft_cmd_seq #(
    .N_POINTS(8), .IDX_W(IDX_W), .STAGE_CYCLES(SC), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_b(op_b),
    .ld_we(ld_we), .ld_idx(ld_idx), .stage_go(stage_go), .stage_idx(stage_idx),
    .inverse(inverse), .exp_sel(exp_sel), .done(done), .busy(busy), .err(err)
`ifdef FFT_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    cmd_valid = 1'b0; aluop = 2'b00; funct3 = 3'h0; funct7 = 7'h0; op_b = '0;
  endtask

  task automatic drive(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [DW-1:0] b);
    cmd_valid = 1'b1; aluop = a; funct3 = f3; funct7 = f7; op_b = b;
  endtask

  task automatic cmd(input logic [2:0] op, input int unsigned b);
    drive(ALU_RTYPE, 3'h0, {op, 4'h0}, DW'(b));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic load_all(input int n);
    for (int i = 0; i < n; i++) begin
      cmd(FFT_OP_LOAD, i);
      @(negedge clk);
      if ({ld_we, ld_idx, cmd_ready} !== {1'b1, IDX_W'(i), 1'b1}) begin
        $display("FAIL load_strobe[%0d]: got we=%b idx=%0d rdy=%b want we=1 idx=%0d rdy=1",
                 i, ld_we, ld_idx, cmd_ready, i);
      end else pass_cnt++;
      total++;
      tick();
    end
    idle();
  endtask

  // Issue a CAL, expect the cycle-exact stage trace; optionally hold a LOAD during the stall.
  task automatic run_cal(input logic inv, input logic hold);
    obs_t e, o;
    logic stalled_we = 1'b0;
    cmd(inv ? FFT_OP_CAL_IFFT : FFT_OP_CAL_FFT, 0);
    @(negedge clk);
    if ({cmd_ready, busy} !== 2'b10) begin
      $display("FAIL cal_issue: got rdy=%b busy=%b want rdy=1 busy=0", cmd_ready, busy);
    end else pass_cnt++;
    total++;
    tick();
    if (hold) cmd(FFT_OP_LOAD, 0);
    else      idle();
    for (int c = 1; c <= int'(CALC_CYC); c++) begin
      e = '{ready: 1'b0, go: ((c - 1) % SC) == 0, stg: STG_W'((c - 1) / SC),
            inv: inv, dn: 1'b0, bsy: 1'b1};
      exp_q.push_back(e);
    end
    exp_q.push_back('{ready: 1'b0, go: 1'b0, stg: '0, inv: 1'b0, dn: 1'b1, bsy: 1'b0});
    exp_q.push_back('{ready: 1'b1, go: 1'b0, stg: '0, inv: 1'b0, dn: 1'b0, bsy: 1'b0});
    for (int c = 1; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      o = {cmd_ready, stage_go, stage_idx, inverse, done, busy};
      if (o !== e) begin
        $display("FAIL cal_trace[cycle %0d]: got rdy/go/stg/inv/done/busy=%b want %b", c, o, e);
      end else pass_cnt++;
      total++;
      if (!cmd_ready && ld_we) stalled_we = 1'b1;
      tick();
    end
    idle();
    if (stalled_we !== 1'b0) begin
      $display("FAIL stall_no_accept: got ld_we while stalled=%b want 0", stalled_we);
    end else pass_cnt++;
    total++;
    @(negedge clk);
    if (err !== 1'b0) begin
      $display("FAIL cal_err: got err=%b want 0", err);
    end else pass_cnt++;
    total++;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    if ({cmd_ready, ld_we, ld_idx, stage_go, stage_idx, inverse, exp_sel, done, busy, err}
        !== {1'b1, 1'b0, 6'd0, 1'b0, 3'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: got rdy=%b we=%b go=%b stg=%0d inv=%b sel=%0h done=%b busy=%b err=%b",
               cmd_ready, ld_we, stage_go, stage_idx, inverse, exp_sel, done, busy, err);
    end else pass_cnt++;
    total++;
`ifdef FFT_PERF_EN
    if (perf_cycles !== 32'd0) begin
      $display("FAIL reset_perf: got %0d want 0", perf_cycles);
    end else pass_cnt++;
    total++;
`endif
    tick();
  endtask

  task automatic test_fft_and_export();
    do_reset();
    load_all(8);
    run_cal(1'b0, 1'b0);
    cmd(FFT_OP_EXP_IM, 5);
    @(negedge clk);
    if (exp_sel !== 7'b1_000101) begin
      $display("FAIL exp_im5: got %b want 1000101", exp_sel);
    end else pass_cnt++;
    total++;
    tick();
    cmd(FFT_OP_EXP_RE, 2);
    @(negedge clk);
    if (exp_sel !== 7'b0_000010) begin
      $display("FAIL exp_re2: got %b want 0000010", exp_sel);
    end else pass_cnt++;
    total++;
    tick();
    cmd(FFT_OP_LOAD, 3);
    tick();
    cmd(FFT_OP_EXP_RE, 0);
    @(negedge clk);
    if (exp_sel !== 7'd0) begin
      $display("FAIL exp_after_load: got %b want 0", exp_sel);
    end else pass_cnt++;
    total++;
    tick();
    idle();
    @(negedge clk);
    if (err !== 1'b1) begin
      $display("FAIL exp_invalid_err: got err=%b want 1", err);
    end else pass_cnt++;
    total++;
    tick();
  endtask

  task automatic test_ifft_stall();
    do_reset();
    load_all(8);
    run_cal(1'b1, 1'b1);
  endtask

  task automatic test_incomplete_mask();
    do_reset();
    load_all(7);
    cmd(FFT_OP_CAL_IFFT, 0);
    tick();
    idle();
    @(negedge clk);
    if ({busy, cmd_ready, err, stage_go} !== 4'b0110) begin
      $display("FAIL incomplete_cal: got busy/rdy/err/go=%b want 0110",
               {busy, cmd_ready, err, stage_go});
    end else pass_cnt++;
    total++;
    tick();
  endtask

  task automatic test_bad_load();
    do_reset();
    load_all(7);
    cmd(FFT_OP_LOAD, 9);
    @(negedge clk);
    if (ld_we !== 1'b0) begin
      $display("FAIL bad_load_we: got %b want 0", ld_we);
    end else pass_cnt++;
    total++;
    tick();
    cmd(FFT_OP_CAL_FFT, 0);
    tick();
    idle();
    @(negedge clk);
    if ({busy, err} !== 2'b01) begin
      $display("FAIL bad_load_mask: got busy=%b err=%b want busy=0 err=1", busy, err);
    end else pass_cnt++;
    total++;
    tick();
  endtask

  task automatic test_unknown();
    logic [1:0] ta [6];
    logic [2:0] tf3[6];
    logic [6:0] tf7[6];
    ta = '{ALU_RTYPE, ALU_RTYPE, 2'b00, ALU_RTYPE, ALU_RTYPE, ALU_RTYPE};
    tf3 = '{3'h0, 3'h1, 3'h0, 3'h0, 3'h0, 3'h0};
    tf7 = '{{FFT_OP_LOAD, 4'h1}, {FFT_OP_LOAD, 4'h0}, {FFT_OP_CAL_FFT, 4'h0},
            {FFT_OP_CAL_FFT, 4'h8}, {3'b111, 4'h0}, {3'b000, 4'h0}};
    do_reset();
    load_all(8);
    for (int k = 0; k < 6; k++) begin
      drive(ta[k], tf3[k], tf7[k], 32'd2);
      @(negedge clk);
      if ({cmd_ready, ld_we, exp_sel} !== {1'b1, 1'b0, 7'd0}) begin
        $display("FAIL unknown_cmd[%0d]: got rdy=%b we=%b sel=%0h want rdy=1 we=0 sel=0",
                 k, cmd_ready, ld_we, exp_sel);
      end else pass_cnt++;
      total++;
      tick();
      idle();
      @(negedge clk);
      if ({busy, err} !== 2'b00) begin
        $display("FAIL unknown_noaction[%0d]: got busy=%b err=%b want 0 0", k, busy, err);
      end else pass_cnt++;
      total++;
      tick();
    end
`ifndef FFT_PERF_EN
    cmd(FFT_OP_PERF, 0);
    @(negedge clk);
    if ({cmd_ready, exp_sel} !== {1'b1, 7'd0}) begin
      $display("FAIL perf_op_unknown: got rdy=%b sel=%0h want rdy=1 sel=0", cmd_ready, exp_sel);
    end else pass_cnt++;
    total++;
    tick();
    idle();
`endif
  endtask

  task automatic test_reset_mid_calc();
    logic saw_done = 1'b0;
    do_reset();
    load_all(8);
    cmd(FFT_OP_CAL_FFT, 0);
    tick();
    idle();
    tick();
    tick();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    if ({busy, cmd_ready, stage_go, stage_idx, done} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      $display("FAIL reset_mid: got busy=%b rdy=%b go=%b stg=%0d done=%b want 0 1 0 0 0",
               busy, cmd_ready, stage_go, stage_idx, done);
    end else pass_cnt++;
    total++;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      tick();
    end
    if (saw_done !== 1'b0) begin
      $display("FAIL reset_mid_no_done: got done seen=%b want 0", saw_done);
    end else pass_cnt++;
    total++;
    cmd(FFT_OP_CAL_FFT, 0);
    tick();
    idle();
    @(negedge clk);
    if ({busy, err} !== 2'b01) begin
      $display("FAIL reset_mid_reload: got busy=%b err=%b want 0 1", busy, err);
    end else pass_cnt++;
    total++;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_all(8);
    run_cal(1'b0, 1'b0);
    cmd(FFT_OP_CAL_FFT, 0);
    tick();
    idle();
    @(negedge clk);
    if ({busy, err, cmd_ready} !== 3'b011) begin
      $display("FAIL back_to_back: got busy=%b err=%b rdy=%b want 0 1 1", busy, err, cmd_ready);
    end else pass_cnt++;
    total++;
    tick();
  endtask

`ifdef FFT_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int t = 0; t < 2; t++) begin
      load_all(8);
      run_cal(1'b0, 1'b0);
    end
    cmd(FFT_OP_PERF, 0);
    @(negedge clk);
    if ({exp_sel, perf_cycles} !== {7'h7f, 32'(2 * CALC_CYC)}) begin
      $display("FAIL perf_rd: got sel=%0h perf=%0d want sel=7f perf=%0d",
               exp_sel, perf_cycles, 2 * CALC_CYC);
    end else pass_cnt++;
    total++;
    tick();
    idle();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_fft_and_export();
    test_ifft_stall();
    test_incomplete_mask();
    test_bad_load();
    test_unknown();
    test_reset_mid_calc();
    test_back_to_back();
`ifdef FFT_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
